// File: rtl/bram_fifo_2psync_if.sv
// Stream and external-BRAM signal bundle for bram_fifo_2psync.
// The slave modport is the FIFO controller view; master is the surrounding system view.
interface bram_fifo_2psync_if #(
  parameter int ADDR = 10,
  parameter int DATA = 8
);

  logic [DATA-1:0] in_data;
  logic            in_valid;
  logic            in_ready;

  logic [DATA-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  logic [ADDR:0]   level;

  logic            ram_we;
  logic [ADDR-1:0] ram_waddr;
  logic [DATA-1:0] ram_wdata;
  logic [ADDR-1:0] ram_raddr;
  logic [DATA-1:0] ram_rdata;

  modport slave (
    input  in_data, in_valid, out_ready, ram_rdata,
    output in_ready, out_data, out_valid, level,
           ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  modport master (
    output in_data, in_valid, out_ready, ram_rdata,
    input  in_ready, out_data, out_valid, level,
           ram_we, ram_waddr, ram_wdata, ram_raddr
  );

endinterface

// File: rtl/bram_fifo_2psync.sv
// Synchronous FIFO controller for an external two-port BRAM with a 2-entry output stage.
// Define BRAM_FIFO_LEVEL_EN to build the occupancy counter on level; otherwise level is tied to 0.
module bram_fifo_2psync #(
  parameter int ADDR = 10,
  parameter int DATA = 8
) (
  input  logic              clk,
  input  logic              reset,
  bram_fifo_2psync_if.slave bus
);

  localparam logic [ADDR:0] PTR_ONE   = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0] PTR_ZERO  = {(ADDR+1){1'b0}};
  localparam logic [ADDR:0] RAM_WORDS = {1'b1, {ADDR{1'b0}}};

  logic [ADDR:0]   wp_q, wp_d;
  logic [ADDR:0]   rp_q, rp_d;
  logic [1:0]      occ_q, occ_d;
  logic            pend_q, pend_d;
  logic [DATA-1:0] head_q, head_d;
  logic [DATA-1:0] skid_q, skid_d;
  logic            out_valid_q, out_valid_d;

  logic [ADDR:0]   rc_s;
  logic            ram_full_s;
  logic            ram_empty_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            pop_s;
  logic            issue_s;
  logic [1:0]      occ_after_s;
  logic [2:0]      proj_s;

  assign rc_s        = wp_q - rp_q;
  assign ram_full_s  = (rc_s == RAM_WORDS);
  assign ram_empty_s = (rc_s == PTR_ZERO);
  assign in_ready_s  = ~reset & ~ram_full_s;
  assign accept_s    = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_q & bus.out_ready;

  // Stage fill after this cycle's pop plus the word already on its way back from RAM.
  assign occ_after_s = occ_q - {1'b0, pop_s};
  assign proj_s      = {1'b0, occ_after_s} + {2'b00, pend_q};
  assign issue_s     = ~ram_empty_s & (proj_s < 3'd2);

  assign bus.in_ready  = in_ready_s;
  assign bus.ram_we    = accept_s;
  assign bus.ram_waddr = wp_q[ADDR-1:0];
  assign bus.ram_wdata = bus.in_data;
  assign bus.ram_raddr = rp_q[ADDR-1:0];
  assign bus.out_data  = head_q;
  assign bus.out_valid = out_valid_q;

  // Next-state for pointers and the head/skid output stage.
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    head_d      = head_q;
    skid_d      = skid_q;
    pend_d      = 1'b0;
    occ_d       = 2'd0;
    out_valid_d = 1'b0;

    if (accept_s) begin
      wp_d = wp_q + PTR_ONE;
    end else begin
      wp_d = wp_q;
    end

    if (issue_s) begin
      rp_d = rp_q + PTR_ONE;
    end else begin
      rp_d = rp_q;
    end

    if (pop_s && (occ_q == 2'd2)) begin
      head_d = skid_q;
    end else if (pend_q && (occ_after_s == 2'd0)) begin
      head_d = bus.ram_rdata;
    end else begin
      head_d = head_q;
    end

    if (pend_q && (occ_after_s == 2'd1)) begin
      skid_d = bus.ram_rdata;
    end else begin
      skid_d = skid_q;
    end

    pend_d      = issue_s;
    occ_d       = proj_s[1:0];
    out_valid_d = (proj_s != 3'd0);
  end

  // State registers; reset discards contents and any in-flight read immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q        <= PTR_ZERO;
      rp_q        <= PTR_ZERO;
      occ_q       <= 2'd0;
      pend_q      <= 1'b0;
      head_q      <= {DATA{1'b0}};
      skid_q      <= {DATA{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR:0] level_q, level_d;

  // Word count across RAM, pending read and output stage.
  always_comb begin
    level_d = level_q;
    case ({accept_s, pop_s})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
  end

  // Level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= PTR_ZERO;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.level = level_q;
`else
  assign bus.level = PTR_ZERO;
`endif

endmodule
